// File: rtl/overlay_pixel_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | overlay_pixel_gen                                                          |
// | Test-pattern pixel generator with frame border and one overlay box,        |
// | two-stage pipeline from sync/DE inputs to RGB and sync outputs.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module overlay_pixel_gen #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic        in_de,
    input  logic [3:0]  color_mode,
    input  logic        border_en,
    input  logic [11:0] box_x,
    input  logic [11:0] box_y,
    input  logic [11:0] box_w,
    input  logic [11:0] box_h,
    input  logic [23:0] box_color,
    output logic        out_hs,
    output logic        out_vs,
    output logic        out_de,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic        frame_start
);

    localparam logic [11:0] c_CNT_MAX = 12'hFFF;
    localparam logic [23:0] c_RED     = 24'hFF0000;

    if (LAT != 2) begin : g_lat_check
        $error("overlay_pixel_gen: only LAT=2 is supported");
    end

    logic        r_de_d1, r_vs_d1;
    logic [11:0] r_x_cnt, r_y_cnt, r_line_len, r_frame_lines;
    logic        r_frame_start;
    logic [11:0] r_sbox_x, r_sbox_y, r_sbox_w, r_sbox_h;
    logic [23:0] r_sbox_color;
    logic [3:0]  r_smode;

    logic [23:0] r_s1_bg;
    logic        r_s1_in_box, r_s1_border, r_s1_de, r_s1_hs, r_s1_vs;
    logic [23:0] r_s2_rgb;
    logic        r_s2_de, r_s2_hs, r_s2_vs;

    logic        w_de_fall, w_vs_fall;
    logic [12:0] w_x_end, w_y_end;
    logic        w_in_box, w_border;
    logic [23:0] w_bg, w_mix;

    assign w_de_fall = r_de_d1 & ~in_de;
    assign w_vs_fall = r_vs_d1 & ~in_vs;

    // Pixel coordinate is the counter value held during the DE cycle itself.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_de_d1       <= 1'b0;
            r_vs_d1       <= 1'b0;
            r_x_cnt       <= '0;
            r_y_cnt       <= '0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_frame_start <= 1'b0;
            r_sbox_x      <= '0;
            r_sbox_y      <= '0;
            r_sbox_w      <= '0;
            r_sbox_h      <= '0;
            r_sbox_color  <= '0;
            r_smode       <= '0;
        end else begin
            r_de_d1       <= in_de;
            r_vs_d1       <= in_vs;
            r_frame_start <= w_vs_fall;
            if (!in_de)
                r_x_cnt <= '0;
            else if (r_x_cnt != c_CNT_MAX)
                r_x_cnt <= r_x_cnt + 12'd1;
            if (w_vs_fall)
                r_y_cnt <= '0;
            else if (w_de_fall && r_y_cnt != c_CNT_MAX)
                r_y_cnt <= r_y_cnt + 12'd1;
            if (w_de_fall)
                r_line_len <= r_x_cnt;
            if (w_vs_fall && r_y_cnt != 12'd0)
                r_frame_lines <= r_y_cnt;
            if (w_vs_fall) begin
                r_sbox_x     <= box_x;
                r_sbox_y     <= box_y;
                r_sbox_w     <= box_w;
                r_sbox_h     <= box_h;
                r_sbox_color <= box_color;
                r_smode      <= color_mode;
            end
        end
    end

    // 13-bit end coordinates so a box reaching past 4095 cannot wrap.
    assign w_x_end  = {1'b0, r_sbox_x} + {1'b0, r_sbox_w};
    assign w_y_end  = {1'b0, r_sbox_y} + {1'b0, r_sbox_h};
    assign w_in_box = (r_x_cnt >= r_sbox_x) && ({1'b0, r_x_cnt} < w_x_end) &&
                      (r_y_cnt >= r_sbox_y) && ({1'b0, r_y_cnt} < w_y_end);
    assign w_border = border_en &&
                      ((r_x_cnt == 12'd0) || (r_y_cnt == 12'd0) ||
                       ((r_line_len != 12'd0) && (r_x_cnt == r_line_len - 12'd1)) ||
                       ((r_frame_lines != 12'd0) && (r_y_cnt == r_frame_lines - 12'd1)));

    always_comb begin
        w_bg = 24'h000000;
        case (r_smode)
            4'd1: w_bg = 24'hFFFFFF;
            4'd2: begin
                case (r_x_cnt[10:8])
                    3'd0: w_bg = 24'hFFFFFF;
                    3'd1: w_bg = 24'hFFFF00;
                    3'd2: w_bg = 24'h00FFFF;
                    3'd3: w_bg = 24'h00FF00;
                    3'd4: w_bg = 24'hFF00FF;
                    3'd5: w_bg = 24'hFF0000;
                    3'd6: w_bg = 24'h0000FF;
                    default: w_bg = 24'h000000;
                endcase
            end
            4'd3: w_bg = {3{r_x_cnt[7:0]}};
            4'd4: w_bg = (r_x_cnt[5] ^ r_y_cnt[5]) ? 24'hFFFFFF : 24'h000000;
            4'd5: w_bg = {3{r_y_cnt[7:0]}};
            default: w_bg = 24'h000000;
        endcase
    end

    always_comb begin
        w_mix = 24'h000000;
        if (r_s1_de) begin
            if (r_s1_border)
                w_mix = c_RED;
            else if (r_s1_in_box)
                w_mix = r_sbox_color;
            else
                w_mix = r_s1_bg;
        end
    end

    // Sync registers reset to the inactive (high) level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_bg     <= '0;
            r_s1_in_box <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_de     <= 1'b0;
            r_s1_hs     <= 1'b1;
            r_s1_vs     <= 1'b1;
            r_s2_rgb    <= '0;
            r_s2_de     <= 1'b0;
            r_s2_hs     <= 1'b1;
            r_s2_vs     <= 1'b1;
        end else begin
            r_s1_bg     <= w_bg;
            r_s1_in_box <= w_in_box;
            r_s1_border <= w_border;
            r_s1_de     <= in_de;
            r_s1_hs     <= in_hs;
            r_s1_vs     <= in_vs;
            r_s2_rgb    <= w_mix;
            r_s2_de     <= r_s1_de;
            r_s2_hs     <= r_s1_hs;
            r_s2_vs     <= r_s1_vs;
        end
    end

    assign out_hs      = r_s2_hs;
    assign out_vs      = r_s2_vs;
    assign out_de      = r_s2_de;
    assign out_r       = r_s2_rgb[23:16];
    assign out_g       = r_s2_rgb[15:8];
    assign out_b       = r_s2_rgb[7:0];
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_overlay_pixel_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_overlay_pixel_gen                                                       |
// | Directed self-checking bench for overlay_pixel_gen.                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_overlay_pixel_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_hs, in_vs, in_de;
    logic [3:0]  color_mode;
    logic        border_en;
    logic [11:0] box_x, box_y, box_w, box_h;
    logic [23:0] box_color;
    logic        out_hs, out_vs, out_de, frame_start;
    logic [7:0]  out_r, out_g, out_b;

    overlay_pixel_gen #(.LAT(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
        .color_mode(color_mode), .border_en(border_en),
        .box_x(box_x), .box_y(box_y), .box_w(box_w), .box_h(box_h),
        .box_color(box_color),
        .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected sync/DE/coordinate history: h1 = one cycle old, h2 = two.
    logic h1_de = 1'b0, h1_hs = 1'b1, h1_vs = 1'b1;
    logic h2_de = 1'b0, h2_hs = 1'b1, h2_vs = 1'b1;
    int   h1_x = 0, h1_y = 0, h2_x = 0, h2_y = 0;
    logic prev_vs = 1'b0, fs_pend = 1'b0;

    logic        s_de, s_hs, s_vs, s_fs;
    logic [23:0] s_rgb;

    int sync_err, blank_err, fs_err, fs_cnt, cnt_all, cnt_rect;
    logic [23:0] cnt_color;
    int rect_x0, rect_x1, rect_y0, rect_y1;
    int mid_line = -1;
    logic [11:0] mid_box_x;

    int          n_probe;
    int          probe_x [8];
    int          probe_y [8];
    logic [23:0] probe_val [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        sync_err = 0; blank_err = 0; fs_err = 0; fs_cnt = 0;
        cnt_all = 0; cnt_rect = 0; n_probe = 0;
        for (int i = 0; i < 8; i++) probe_val[i] = 'x;
    endtask

    task automatic add_probe(input int x, input int y);
        probe_x[n_probe] = x;
        probe_y[n_probe] = y;
        n_probe++;
    endtask

    // Sample the outputs, then drive the next input vector.
    task automatic step(input logic rn, input logic de, input logic hs, input logic vs,
                        input int x, input int y);
        @(negedge clk);
        s_de = out_de; s_hs = out_hs; s_vs = out_vs; s_fs = frame_start;
        s_rgb = {out_r, out_g, out_b};
        if (s_de !== h2_de || s_hs !== h2_hs || s_vs !== h2_vs) sync_err++;
        if (s_de !== 1'b1 && s_rgb !== 24'h0) blank_err++;
        if (s_fs !== fs_pend) fs_err++;
        if (s_fs === 1'b1) fs_cnt++;
        if (s_de === 1'b1 && h2_de) begin
            for (int i = 0; i < n_probe; i++)
                if (h2_x == probe_x[i] && h2_y == probe_y[i]) probe_val[i] = s_rgb;
            if (s_rgb === cnt_color) begin
                cnt_all++;
                if (h2_x >= rect_x0 && h2_x <= rect_x1 && h2_y >= rect_y0 && h2_y <= rect_y1)
                    cnt_rect++;
            end
        end
        h2_de = h1_de; h2_hs = h1_hs; h2_vs = h1_vs; h2_x = h1_x; h2_y = h1_y;
        h1_de = de; h1_hs = hs; h1_vs = vs; h1_x = x; h1_y = y;
        if (!rn) begin
            h1_de = 1'b0; h1_hs = 1'b1; h1_vs = 1'b1;
            h2_de = 1'b0; h2_hs = 1'b1; h2_vs = 1'b1;
        end
        fs_pend = rn && prev_vs && !vs;
        prev_vs = rn ? vs : 1'b0;
        reset_n = rn; in_de = de; in_hs = hs; in_vs = vs;
    endtask

    task automatic vsync_blk();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    endtask

    task automatic line(input int w, input int hb, input int y);
        for (int x = 0; x < w; x++) step(1'b1, 1'b1, 1'b1, 1'b1, x, y);
        for (int i = 0; i < hb; i++) step(1'b1, 1'b0, (i == 1 || i == 2) ? 1'b0 : 1'b1, 1'b1, 0, 0);
    endtask

    task automatic frame(input int w, input int h, input int hb);
        vsync_blk();
        for (int y = 0; y < h; y++) begin
            if (y == mid_line) box_x = mid_box_x;
            line(w, hb, y);
        end
    endtask

    task automatic check_clean(input string tag);
        check({tag, "_sync"},  sync_err,  0);
        check({tag, "_blank"}, blank_err, 0);
        check({tag, "_fs"},    fs_err,    0);
    endtask

    initial begin
        reset_n = 1'b0; in_hs = 1'b1; in_vs = 1'b1; in_de = 1'b0;
        color_mode = 4'd0; border_en = 1'b0;
        box_x = '0; box_y = '0; box_w = '0; box_h = '0; box_color = '0;
        cnt_color = 24'h0; rect_x0 = 0; rect_x1 = 0; rect_y0 = 0; rect_y1 = 0;
        mid_box_x = '0;
        clear_stats();

        // Reset with toggling inputs: outputs pinned at reset values.
        for (int i = 0; i < 3; i++) begin
            box_x = 12'(i * 7 + 3); color_mode = 4'(i + 1); border_en = 1'(i);
            step((i == 2) ? 1'b1 : 1'b0, 1'(i % 2 == 0), 1'(i % 2), 1'(i % 2), 0, 0);
            check("reset_outputs", {3'b0, s_hs, s_vs, s_de, s_fs, s_rgb}, {3'b0, 4'b1100, 24'h0});
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);

        // Colour bars, 1280-wide lines.
        clear_stats();
        color_mode = 4'd2; border_en = 1'b0; box_w = '0; box_h = '0;
        add_probe(0, 0); add_probe(256, 0); add_probe(512, 0);
        add_probe(768, 1); add_probe(1024, 1); add_probe(1279, 1);
        frame(1280, 2, 4);
        check_clean("bars");
        check("bars_fs_cnt", fs_cnt, 1);
        check("bars_x0",    probe_val[0], 24'hFFFFFF);
        check("bars_x256",  probe_val[1], 24'hFFFF00);
        check("bars_x512",  probe_val[2], 24'h00FFFF);
        check("bars_x768",  probe_val[3], 24'h00FF00);
        check("bars_x1024", probe_val[4], 24'hFF00FF);
        check("bars_x1279", probe_val[5], 24'hFF00FF);

        // Overlay box on a black background.
        clear_stats();
        color_mode = 4'd0; box_x = 12'd100; box_y = 12'd50; box_w = 12'd10; box_h = 12'd4;
        box_color = 24'h00FF00; cnt_color = 24'h00FF00;
        rect_x0 = 100; rect_x1 = 109; rect_y0 = 50; rect_y1 = 53;
        add_probe(100, 50); add_probe(109, 53); add_probe(110, 53); add_probe(99, 50); add_probe(105, 54);
        frame(112, 56, 4);
        check_clean("box");
        check("box_count", cnt_all, 40);
        check("box_in_rect", cnt_rect, 40);
        check("box_tl", probe_val[0], 24'h00FF00);
        check("box_br", probe_val[1], 24'h00FF00);
        check("box_right_out", probe_val[2], 24'h000000);
        check("box_left_out", probe_val[3], 24'h000000);
        check("box_below_out", probe_val[4], 24'h000000);

        clear_stats();
        box_w = 12'd0;
        frame(112, 56, 4);
        check("box_w0_count", cnt_all, 0);

        // Shadowing: box_x moved mid-frame takes effect only next frame.
        clear_stats();
        box_w = 12'd10; mid_line = 20; mid_box_x = 12'd20;
        frame(112, 56, 4);
        check("shadow_cur_rect", cnt_rect, 40);
        check("shadow_cur_total", cnt_all, 40);
        clear_stats();
        mid_line = -1; rect_x0 = 20; rect_x1 = 29;
        frame(112, 56, 4);
        check("shadow_next_rect", cnt_rect, 40);
        check("shadow_next_fs", fs_cnt, 1);
        check_clean("shadow");

        // Border: measured edges appear only after measurement.
        color_mode = 4'd1; border_en = 1'b1; box_w = 12'd0;
        step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        clear_stats();
        add_probe(0, 5); add_probe(7, 0); add_probe(7, 15); add_probe(7, 7);
        frame(32, 16, 4);
        check("brd1_x0", probe_val[0], 24'hFF0000);
        check("brd1_y0", probe_val[1], 24'hFF0000);
        check("brd1_ylast_off", probe_val[2], 24'hFFFFFF);
        check("brd1_inner", probe_val[3], 24'hFFFFFF);
        clear_stats();
        add_probe(7, 15); add_probe(31, 7); add_probe(30, 7); add_probe(7, 14);
        frame(32, 16, 4);
        check("brd2_ylast", probe_val[0], 24'hFF0000);
        check("brd2_xlast", probe_val[1], 24'hFF0000);
        check("brd2_x30", probe_val[2], 24'hFFFFFF);
        check("brd2_y14", probe_val[3], 24'hFFFFFF);
        check_clean("brd");

        // Reset in the middle of a line, then a full clean frame.
        border_en = 1'b0;
        vsync_blk();
        for (int y = 0; y < 10; y++) line(32, 4, y);
        for (int x = 0; x < 10; x++) step(1'b1, 1'b1, 1'b1, 1'b1, x, 10);
        step(1'b0, 1'b1, 1'b1, 1'b1, 10, 10);
        step(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        check("midrst_de", {7'b0, s_de, s_rgb}, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        clear_stats();
        cnt_color = 24'hFFFFFF; rect_x0 = 0; rect_x1 = 31; rect_y0 = 0; rect_y1 = 15;
        add_probe(0, 0); add_probe(31, 15);
        frame(32, 16, 4);
        check_clean("midrst");
        check("midrst_white", cnt_rect, 512);
        check("midrst_p00", probe_val[0], 24'hFFFFFF);
        check("midrst_plast", probe_val[1], 24'hFFFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
